// File: rtl/stopwatch_pkg.sv
// Shared FSM encoding, BCD limits and carry helper for the stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] DIGIT_MAX  = 4'd9;
  localparam int         NUM_DIGITS = 4;

  // High when every digit below position n sits at its max.
  function automatic logic all_max_below(input logic [NUM_DIGITS-1:0] at_max, input int n);
    logic r;
    r = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++)
      if (j < n && !at_max[j]) r = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade counter digit; wraps 9 -> 0 on inc and flags when at 9.
module bcd_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] val,
  output logic       at_max
);
  import stopwatch_pkg::*;

  logic [3:0] r_val;

  // >= keeps an illegal code from ever counting upward.
  always_ff @(posedge clk) begin
    if (rst)      r_val <= 4'd0;
    else if (clr) r_val <= 4'd0;
    else if (inc) r_val <= (r_val >= DIGIT_MAX) ? 4'd0 : r_val + 4'd1;
  end

  assign val    = r_val;
  assign at_max = (r_val == DIGIT_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch: run/pause/clear FSM, tick prescaler, 4-digit BCD count, lap capture.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] bcd,
  output logic [15:0] lap_bcd,
  output logic        lap_valid,
  output logic        running,
  output logic        ovf
);
  import stopwatch_pkg::*;

  localparam int             PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_MAX = PW'(TICK_DIV - 1);

  state_t                          r_state, w_state_nxt;
  logic [PW-1:0]                   r_pre;
  logic                            w_tick, w_clr_cnt, w_lap_acc;
  logic [NUM_DIGITS:0]             w_carry;
  logic [NUM_DIGITS-1:0]           w_at_max;
  logic [NUM_DIGITS-1:0][3:0]      w_val;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Clear beats start_stop only in PAUSE; elsewhere clear is ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_clr_cnt   = 1'b0;
    case (r_state)
      IDLE:  if (start_stop) w_state_nxt = RUN;
      RUN:   if (start_stop) w_state_nxt = PAUSE;
      PAUSE: begin
        if (clear) begin
          w_state_nxt = IDLE;
          w_clr_cnt   = 1'b1;
        end else if (start_stop) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_tick    = (r_state == RUN) && (r_pre == PRE_MAX);
  assign w_lap_acc = (r_state == RUN) && lap;

  // Prescaler phase survives PAUSE so resume keeps sub-tick timing.
  always_ff @(posedge clk) begin
    if (rst)                               r_pre <= '0;
    else if (r_state == IDLE || w_clr_cnt) r_pre <= '0;
    else if (r_state == RUN)               r_pre <= w_tick ? '0 : r_pre + PW'(1);
  end

  for (genvar g = 0; g <= NUM_DIGITS; g++) begin : g_carry
    assign w_carry[g] = w_tick & all_max_below(w_at_max, g);
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .rst    (rst),
      .clr    (w_clr_cnt),
      .inc    (w_carry[g]),
      .val    (w_val[g]),
      .at_max (w_at_max[g])
    );
  end

  assign bcd = w_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      running   <= 1'b0;
      ovf       <= 1'b0;
      lap_valid <= 1'b0;
      lap_bcd   <= '0;
    end else begin
      running   <= (w_state_nxt == RUN);
      ovf       <= w_carry[NUM_DIGITS];
      lap_valid <= w_lap_acc;
      if (w_lap_acc) lap_bcd <= bcd;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench: vector table on a TICK_DIV=10 instance, wrap sequence on TICK_DIV=1.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        a_rst, a_ss, a_cl, a_lp;
  logic [15:0] a_bcd, a_lap_bcd;
  logic        a_lapv, a_run, a_ovf;
  logic        b_rst, b_ss, b_cl, b_lp;
  logic [15:0] b_bcd, b_lap_bcd;
  logic        b_lapv, b_run, b_ovf;

  int checks   = 0;
  int failures = 0;
  int digit_bad = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(10)) u_a (
    .clk(clk), .rst(a_rst), .start_stop(a_ss), .clear(a_cl), .lap(a_lp),
    .bcd(a_bcd), .lap_bcd(a_lap_bcd), .lap_valid(a_lapv), .running(a_run), .ovf(a_ovf)
  );

  stopwatch_ctrl #(.TICK_DIV(1)) u_b (
    .clk(clk), .rst(b_rst), .start_stop(b_ss), .clear(b_cl), .lap(b_lp),
    .bcd(b_bcd), .lap_bcd(b_lap_bcd), .lap_valid(b_lapv), .running(b_run), .ovf(b_ovf)
  );

  // No digit may ever show a code above 9.
  always @(negedge clk) begin
    if (!a_rst && !b_rst) begin
      for (int d = 0; d < 4; d++) begin
        if (a_bcd[d*4 +: 4] > 4'd9) digit_bad++;
        if (b_bcd[d*4 +: 4] > 4'd9) digit_bad++;
      end
    end
  end

  typedef struct {
    logic        rst, ss, cl, lp;
    int          n;
    logic [15:0] bcd;
    logic        run, lapv;
    logic [15:0] lapbcd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ovf_cnt;
    // rst ss cl lp  n  bcd run lapv lap_bcd ; first input edge, then n-1 quiet edges
    tbl.push_back('{0,0,0,0,   5,16'h0000,0,0,16'h0000}); // no start without start_stop
    tbl.push_back('{0,1,0,0,   1,16'h0000,1,0,16'h0000}); // enter RUN
    tbl.push_back('{0,0,0,0,   9,16'h0000,1,0,16'h0000});
    tbl.push_back('{0,0,0,0,   1,16'h0001,1,0,16'h0000}); // first tick at 10
    tbl.push_back('{0,0,0,0,  90,16'h0010,1,0,16'h0000});
    tbl.push_back('{0,0,0,0, 139,16'h0023,1,0,16'h0000}); // tick pending
    tbl.push_back('{0,0,1,1,   1,16'h0024,1,1,16'h0023}); // lap on tick edge (cl ignored in RUN)
    tbl.push_back('{0,0,0,0,   1,16'h0024,1,0,16'h0023});
    tbl.push_back('{0,0,0,0, 749,16'h0099,1,0,16'h0023});
    tbl.push_back('{0,0,0,0,   9,16'h0099,1,0,16'h0023});
    tbl.push_back('{0,0,0,0,   1,16'h0100,1,0,16'h0023}); // two-digit carry in one edge
    tbl.push_back('{0,0,0,0,3560,16'h0456,1,0,16'h0023});
    tbl.push_back('{0,0,0,0,   5,16'h0456,1,0,16'h0023});
    tbl.push_back('{1,1,0,1,   1,16'h0000,0,0,16'h0000}); // rst beats start_stop/lap
    tbl.push_back('{0,0,0,0,  30,16'h0000,0,0,16'h0000});
    tbl.push_back('{0,1,0,0,   1,16'h0000,1,0,16'h0000}); // P0
    tbl.push_back('{0,0,0,0,  73,16'h0007,1,0,16'h0000});
    tbl.push_back('{0,1,0,0,   1,16'h0007,0,0,16'h0000}); // pause, phase 4
    tbl.push_back('{0,0,0,0,  50,16'h0007,0,0,16'h0000});
    tbl.push_back('{0,1,0,0,   1,16'h0007,1,0,16'h0000}); // resume R0
    tbl.push_back('{0,0,0,0,   5,16'h0007,1,0,16'h0000});
    tbl.push_back('{0,0,0,0,   1,16'h0008,1,0,16'h0000}); // 6 after resume
    tbl.push_back('{0,0,1,0,   1,16'h0008,1,0,16'h0000}); // clear in RUN ignored
    tbl.push_back('{0,1,0,0,   1,16'h0008,0,0,16'h0000});
    tbl.push_back('{0,0,1,0,   1,16'h0000,0,0,16'h0000}); // clear in PAUSE
    tbl.push_back('{0,1,0,0,   1,16'h0000,1,0,16'h0000});
    tbl.push_back('{0,0,0,0,   9,16'h0000,1,0,16'h0000});
    tbl.push_back('{0,0,0,0,   1,16'h0001,1,0,16'h0000}); // prescaler was zeroed
    tbl.push_back('{0,1,0,0,   1,16'h0001,0,0,16'h0000});
    tbl.push_back('{0,0,0,1,   1,16'h0001,0,0,16'h0000}); // lap in PAUSE ignored
    tbl.push_back('{0,1,1,0,   1,16'h0000,0,0,16'h0000}); // clear wins in PAUSE
    tbl.push_back('{0,1,1,0,   1,16'h0000,1,0,16'h0000}); // start wins in IDLE
    tbl.push_back('{0,0,0,0,  30,16'h0003,1,0,16'h0000});
    tbl.push_back('{0,1,0,1,   1,16'h0003,0,1,16'h0003}); // lap + pause together
    tbl.push_back('{0,0,0,0,   1,16'h0003,0,0,16'h0003});

    a_rst = 1'b1; a_ss = 1'b0; a_cl = 1'b0; a_lp = 1'b0;
    b_rst = 1'b1; b_ss = 1'b0; b_cl = 1'b0; b_lp = 1'b0;
    repeat (2) edge1();
    a_rst = 1'b0;
    b_rst = 1'b0;
    chk("rst_bcd",     32'(a_bcd),     32'h0);
    chk("rst_running", 32'(a_run),     32'h0);
    chk("rst_lap_bcd", 32'(a_lap_bcd), 32'h0);
    chk("rst_lapv",    32'(a_lapv),    32'h0);
    chk("rst_ovf",     32'(a_ovf),     32'h0);
    chk("rst_b_bcd",   32'(b_bcd),     32'h0);

    foreach (tbl[i]) begin
      a_rst = tbl[i].rst; a_ss = tbl[i].ss; a_cl = tbl[i].cl; a_lp = tbl[i].lp;
      for (int k = 0; k < tbl[i].n; k++) begin
        edge1();
        a_rst = 1'b0; a_ss = 1'b0; a_cl = 1'b0; a_lp = 1'b0;
      end
      chk($sformatf("v%0d_bcd", i),     32'(a_bcd),     32'(tbl[i].bcd));
      chk($sformatf("v%0d_running", i), 32'(a_run),     32'(tbl[i].run));
      chk($sformatf("v%0d_lapv", i),    32'(a_lapv),    32'(tbl[i].lapv));
      chk($sformatf("v%0d_lap_bcd", i), 32'(a_lap_bcd), 32'(tbl[i].lapbcd));
      chk($sformatf("v%0d_ovf", i),     32'(a_ovf),     32'h0);
    end

    // TICK_DIV=1: one tick per RUN cycle, wrap after 10000 ticks.
    ovf_cnt = 0;
    b_ss = 1'b1;
    edge1();
    b_ss = 1'b0;
    chk("b_running", 32'(b_run), 32'h1);
    for (int k = 0; k < 9999; k++) begin
      edge1();
      if (b_ovf) ovf_cnt++;
    end
    chk("b_bcd_9999", 32'(b_bcd), 32'h9999);
    chk("b_no_early_ovf", 32'(ovf_cnt), 32'h0);
    edge1();
    chk("b_wrap_bcd", 32'(b_bcd), 32'h0000);
    chk("b_wrap_ovf", 32'(b_ovf), 32'h1);
    chk("b_wrap_running", 32'(b_run), 32'h1);
    edge1();
    chk("b_post_bcd", 32'(b_bcd), 32'h0001);
    chk("b_post_ovf", 32'(b_ovf), 32'h0);
    chk("digit_range", 32'(digit_bad), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 10, clk cycles per count tick; legal range 1..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start_stop  input  1  one-cycle pulse; toggles run/pause.
REQ-005 SHALL have port clear  input  1  one-cycle pulse; zeroes the count when not running.
REQ-006 SHALL have port lap  input  1  one-cycle pulse; captures the current count.
REQ-007 SHALL have port bcd  output  16  live count, 4 BCD digits; [3:0] is the least significant digit.
REQ-008 SHALL have port lap_bcd  output  16  count captured by the last accepted lap.
REQ-009 SHALL have port lap_valid  output  1  one-cycle pulse, the cycle after lap_bcd updates.
REQ-010 SHALL have port running  output  1  high while in state RUN.
REQ-011 SHALL have port ovf  output  1  one-cycle pulse when the count wraps from 9999 to 0000.

Function
REQ-012 SHALL implement FSM states IDLE (count zero, stopped), RUN, and PAUSE (count held).
REQ-013 SHALL transition IDLE->RUN, RUN->PAUSE and PAUSE->RUN on start_stop.
REQ-014 SHALL transition PAUSE->IDLE on clear, zeroing bcd and the prescaler on the same edge.
REQ-015 SHALL ignore clear in RUN; clear in IDLE is a no-op.
REQ-016 SHALL resolve start_stop and clear asserted together as: clear wins in PAUSE; start_stop wins in IDLE and RUN.
REQ-017 SHALL increment the prescaler 0..TICK_DIV-1 only in RUN, and generate an internal tick on the cycle the prescaler equals TICK_DIV-1 (then the prescaler wraps to 0).
REQ-018 SHALL hold the prescaler in PAUSE so that phase is preserved on resume; it is cleared only in IDLE and on reset.
REQ-019 SHALL increment digit0 on the edge that consumes a tick; the first increment occurs TICK_DIV cycles after the edge that entered RUN.
REQ-020 SHALL ripple the digit increment: digit n increments only when digits 0..n-1 are all 9 and a tick occurs; a digit at 9 wraps to 0 in the same cycle, so no intermediate values are visible.
REQ-021 SHALL, on a tick at 9999, set bcd to 0000, pulse ovf for exactly that cycle, and remain in RUN.
REQ-022 SHALL never let any digit hold a value above 9.
REQ-023 SHALL accept lap only in RUN, loading lap_bcd with bcd's pre-edge value and asserting lap_valid the following cycle; lap is ignored in IDLE and PAUSE.
REQ-024 SHALL, when lap coincides with a tick, capture the pre-increment value.
REQ-025 SHALL, when start_stop and lap arrive together in RUN, both capture the lap and enter PAUSE.
REQ-026 SHALL drive running as a registered decode of state RUN.

Reset
REQ-027 SHALL, on rst high at a clk edge, set the state to IDLE and bcd, lap_bcd, lap_valid, running, ovf and the prescaler all to 0.
REQ-028 SHALL give rst priority over all other inputs, including in mid-RUN and mid-carry cycles.
REQ-029 SHALL NOT restart counting after reset release until start_stop is pulsed.

Structure
REQ-030 SHALL place the state encoding constants (IDLE, RUN, PAUSE) and the BCD digit max (9) in a shared package stopwatch_pkg.
REQ-031 SHALL instantiate four copies of a sub-module bcd_digit (ports: clk, rst, clr, inc, val[3:0], at_max); carry is formed from the at_max flags.
REQ-032 SHALL keep the prescaler and FSM in the top level; total RTL is 120-400 lines.

Verification (TICK_DIV=10 unless noted)
REQ-033 SHALL cover: start_stop pulse from reset -> running=1 next cycle; bcd=0001 exactly 10 cycles after entry; bcd=0010 after 100 cycles.
REQ-034 SHALL cover: run to bcd=0099, then one more tick -> bcd=0100 in one edge with no intermediate value; with TICK_DIV=1, after 10000 ticks -> bcd=0000, a single-cycle ovf, and running=1.
REQ-035 SHALL cover: pause at bcd=0007 with prescaler=4, wait 50 cycles, resume -> bcd stays 0007 while paused and reaches 0008 exactly 6 cycles after resume.
REQ-036 SHALL cover: clear in RUN -> ignored; clear in PAUSE -> bcd=0000 and state IDLE; clear and start_stop together in PAUSE -> IDLE.
REQ-037 SHALL cover: lap at bcd=0023 on a tick cycle -> lap_bcd=0023, lap_valid pulses once, bcd=0024; lap in PAUSE -> no lap_valid.
REQ-038 SHALL cover: rst asserted mid-RUN at bcd=0456 -> all outputs 0 next edge; after release, bcd stays 0000 until start_stop.
